// File: rtl/wash_phase_timer_if.sv
// Timer command interface between the washing-machine controller (master)
// and the phase countdown timer (slave).
interface wash_phase_timer_if;
  logic        i_start;
  logic [15:0] i_state;
  logic [1:0]  i_step;
  logic        i_acc;
  logic [3:0]  o_response;
  logic [15:0] o_time;

  modport master (
    output i_start,
    output i_state,
    output i_step,
    output i_acc,
    input  o_response,
    input  o_time
  );

  modport slave (
    input  i_start,
    input  i_state,
    input  i_step,
    input  i_acc,
    output o_response,
    output o_time
  );
endinterface

// File: rtl/wash_phase_timer.sv
// Phase countdown timer: loads a tick count on each new command, counts down
// at 10 Hz (or the accelerated rate) and raises a one-hot per-phase done flag.
module wash_phase_timer #(
  parameter int unsigned TICK_DIV     = 5_000_000,
  parameter int unsigned TICK_DIV_ACC = 50_000
) (
  input  logic                clk,
  input  logic                rst_n,
  wash_phase_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [31:0] div_q,   div_d;
  logic [1:0]  step_q,  step_d;
  logic [15:0] load_q,  load_d;
  logic [3:0]  resp_q,  resp_d;

  logic [31:0] lim_s;
  logic        load_ev_s;

  assign lim_s = bus.i_acc ? 32'(TICK_DIV_ACC) : 32'(TICK_DIV);

  // A differing command while running or done counts as a fresh load, so a
  // phase change never exposes the previous phase's done flag.
  assign load_ev_s = bus.i_start &&
                     ((state_q == IDLE) ||
                      ({bus.i_step, bus.i_state} != {step_q, load_q}));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      div_q   <= 32'd0;
      step_q  <= 2'd0;
      load_q  <= 16'd0;
      resp_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      step_q  <= step_d;
      load_q  <= load_d;
      resp_q  <= resp_d;
    end
  end

  // Next-state logic: abort beats load, load beats tick/terminal handling
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    step_d  = step_q;
    load_d  = load_q;
    resp_d  = resp_q;

    if (!bus.i_start) begin
      state_d = IDLE;
      cnt_d   = 16'd0;
      div_d   = 32'd0;
      resp_d  = 4'b0000;
    end else if (load_ev_s) begin
      state_d = RUN;
      cnt_d   = bus.i_state;
      step_d  = bus.i_step;
      load_d  = bus.i_state;
      div_d   = 32'd0;
      resp_d  = 4'b0000;
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_q == 16'd0) begin
            state_d = DONE;
            resp_d  = 4'b0001 << step_q;
          // >= so that dropping to the fast limit with div already past it
          // still ticks on the next edge instead of wrapping the prescaler.
          end else if (div_q >= (lim_s - 32'd1)) begin
            div_d = 32'd0;
            cnt_d = cnt_q - 16'd1;
          end else begin
            div_d = div_q + 32'd1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        IDLE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 16'd0;
          div_d   = 32'd0;
          resp_d  = 4'b0000;
        end
      endcase
    end
  end

  assign bus.o_response = resp_q;
  assign bus.o_time     = cnt_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed self-checking bench for wash_phase_timer with TICK_DIV=10, TICK_DIV_ACC=2.
module tb_wash_phase_timer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  wash_phase_timer_if bus ();

  wash_phase_timer #(
    .TICK_DIV     (10),
    .TICK_DIV_ACC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    rst_n       = 1'b0;
    bus.i_start = 1'b1;
    bus.i_state = 16'd5;
    bus.i_step  = 2'd0;
    bus.i_acc   = 1'b0;

    // Reset held with a pending command
    step(1);
    chk("rst_time_a", 32'(bus.o_time), 32'd0);
    chk("rst_resp_a", 32'(bus.o_response), 32'd0);
    step(3);
    chk("rst_time_b", 32'(bus.o_time), 32'd0);
    chk("rst_resp_b", 32'(bus.o_response), 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("rst_first_load", 32'(bus.o_time), 32'd5);

    // Basic run: load 3 on phase 0
    bus.i_start = 1'b0;
    step(1);
    chk("idle_clear", 32'(bus.o_time), 32'd0);
    bus.i_start = 1'b1;
    bus.i_state = 16'd3;
    bus.i_step  = 2'd0;
    step(1);
    chk("basic_load", 32'(bus.o_time), 32'd3);
    chk("basic_resp0", 32'(bus.o_response), 32'd0);
    step(9);
    chk("basic_e9", 32'(bus.o_time), 32'd3);
    step(1);
    chk("basic_e10", 32'(bus.o_time), 32'd2);
    step(10);
    chk("basic_e20", 32'(bus.o_time), 32'd1);
    step(10);
    chk("basic_e30", 32'(bus.o_time), 32'd0);
    chk("basic_e30_resp", 32'(bus.o_response), 32'd0);
    step(1);
    chk("basic_e31_resp", 32'(bus.o_response), 32'b0001);
    step(3);
    chk("basic_hold_resp", 32'(bus.o_response), 32'b0001);
    chk("basic_hold_time", 32'(bus.o_time), 32'd0);

    // Phase chain: new command while DONE
    bus.i_step  = 2'd1;
    bus.i_state = 16'd2;
    step(1);
    chk("chain_resp_clr", 32'(bus.o_response), 32'd0);
    chk("chain_load", 32'(bus.o_time), 32'd2);
    step(20);
    chk("chain_f20_time", 32'(bus.o_time), 32'd0);
    chk("chain_f20_resp", 32'(bus.o_response), 32'd0);
    step(1);
    chk("chain_f21_resp", 32'(bus.o_response), 32'b0010);

    // Accelerate mid-prescale
    bus.i_start = 1'b0;
    step(1);
    bus.i_start = 1'b1;
    bus.i_state = 16'd4;
    bus.i_step  = 2'd2;
    step(1);
    chk("acc_load", 32'(bus.o_time), 32'd4);
    step(5);
    chk("acc_e5", 32'(bus.o_time), 32'd4);
    bus.i_acc = 1'b1;
    step(1);
    chk("acc_e6", 32'(bus.o_time), 32'd3);
    step(1);
    chk("acc_e7", 32'(bus.o_time), 32'd3);
    step(1);
    chk("acc_e8", 32'(bus.o_time), 32'd2);
    step(4);
    chk("acc_e12_time", 32'(bus.o_time), 32'd0);
    chk("acc_e12_resp", 32'(bus.o_response), 32'd0);
    step(1);
    chk("acc_e13_resp", 32'(bus.o_response), 32'b0100);

    // Zero load on phase 3
    bus.i_acc   = 1'b0;
    bus.i_state = 16'd0;
    bus.i_step  = 2'd3;
    step(1);
    chk("zero_time", 32'(bus.o_time), 32'd0);
    chk("zero_resp_e", 32'(bus.o_response), 32'd0);
    step(1);
    chk("zero_resp_e1", 32'(bus.o_response), 32'b1000);

    // Abort a 3-tick run at E+15, then restart with identical command
    bus.i_start = 1'b0;
    step(1);
    bus.i_start = 1'b1;
    bus.i_state = 16'd3;
    bus.i_step  = 2'd0;
    step(1);
    chk("abort_load", 32'(bus.o_time), 32'd3);
    step(14);
    chk("abort_e14", 32'(bus.o_time), 32'd2);
    bus.i_start = 1'b0;
    step(1);
    chk("abort_time", 32'(bus.o_time), 32'd0);
    chk("abort_resp", 32'(bus.o_response), 32'd0);
    step(12);
    chk("abort_idle_resp", 32'(bus.o_response), 32'd0);
    bus.i_start = 1'b1;
    step(1);
    chk("abort_reload", 32'(bus.o_time), 32'd3);

    // Asynchronous reset mid-run clears without waiting for an edge
    step(3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_time", 32'(bus.o_time), 32'd0);
    chk("async_rst_resp", 32'(bus.o_response), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_load", 32'(bus.o_time), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Countdown timer that serves as the responder side of the washing-machine controller's timer command interface. The controller issues a start level, a 16-bit load value in 0.1 s units and a 2-bit phase index. This block loads on every new command and counts down at 10 Hz, or faster when acceleration is requested. It returns a per-phase done flag and the live remaining count, which feeds the time-formatting and display path.

## Interface
- `TICK_DIV`, default 5_000_000: clock cycles per 0.1 s tick in normal mode (50 MHz clk).
- `TICK_DIV_ACC`, default 50_000: clock cycles per tick while `i_acc`=1; must be ≥1 and ≤`TICK_DIV`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  level; 1 = timer enabled, 0 = idle/clear.
- `i_state`  in  16  load value in ticks (0.1 s units), unsigned.
- `i_step`  in  2  phase index selecting which `o_response` bit reports completion.
- `i_acc`  in  1  level; 1 = use `TICK_DIV_ACC`.
- `o_response`  out  4  one-hot done flag, bit[`step_q`]; level, not pulse.
- `o_time`  out  16  remaining ticks (registered count).

## Operation
- Internal registers:
  - `cnt[15:0]`, drives `o_time`.
  - `div`, 32-bit prescaler.
  - `step_q[1:0]` and `load_q[15:0]`, the latched command.
  - FSM states IDLE, RUN, DONE.
- Load event: `i_start`=1 AND (state==IDLE OR `{i_step,i_state}` != `{step_q,load_q}`).
- Priority per edge, highest first: `i_start`=0 > load event > tick/terminal logic.
- `i_start`=0, from any state → IDLE:
  - `cnt`=0, `div`=0, `o_response`=0.
  - `step_q` and `load_q` unchanged.
- Load event → RUN:
  - `cnt`←`i_state`, `step_q`←`i_step`, `load_q`←`i_state`.
  - `div`=0, `o_response`=0.
- RUN with `cnt`==0 → DONE; `o_response`←(4'b1 << `step_q`).
- RUN with `cnt`>0:
  - `lim` = `i_acc` ? `TICK_DIV_ACC` : `TICK_DIV`, evaluated every cycle.
  - If `div` ≥ `lim`-1: tick, meaning `div`←0 and `cnt`←`cnt`-1.
  - Otherwise `div`←`div`+1.
  - The ≥ comparison makes a switch to fast mode with `div` above the new limit tick on the next edge.
- DONE:
  - `cnt` holds 0 and `o_response` holds its bit.
  - Stays until `i_start`=0 or a load event.
- `cnt` never underflows; no decrement occurs at 0.
- Restarting an identical command requires `i_start` low for ≥1 cycle.
- Reserved: none. Every 2-bit `i_step` value maps to one response bit.

## Timing
- Reset values: `o_time`=0, `o_response`=4'b0000, state IDLE, `div`=0, `step_q`=0, `load_q`=0.
- Reset mid-run clears immediately (asynchronous). No response is issued.
- Load latency: `o_time`=`i_state` on the first edge where the load event is sampled.
- Normal mode: first decrement `TICK_DIV` edges after the load edge, then every `TICK_DIV` edges.
- Done latency: `o_response` bit sets 1 edge after `o_time` becomes 0.
  - Load value N, normal mode → response at load edge + N·`TICK_DIV` + 1.
  - Load value 0 → response at load edge + 1.
- A new command arriving while in DONE clears `o_response` on the same edge that reloads `cnt`. The controller never sees a stale flag for the new phase.
- `i_acc` toggles take effect on the same cycle's comparison. No other synchronization is applied; the input is assumed to be already synchronized upstream.

## Test plan
All scenarios use `TICK_DIV`=10, `TICK_DIV_ACC`=2.
- Reset: `rst_n`=0 with `i_start`=1 and `i_state`=5 → `o_time`=0, `o_response`=0 throughout. After release, the load occurs on the first edge.
- Basic run: `i_start`=1, `i_state`=3, `i_step`=0 sampled at edge E → `o_time`=3@E, 2@E+10, 1@E+20, 0@E+30; `o_response`=0001@E+31 and held.
- Phase chain: in DONE with `i_step`→1 and `i_state`→2 at edge F → `o_response`=0000 and `o_time`=2@F; `o_response`=0010@F+21.
- Accelerate: load 4 at E; at `div`=5 (edge E+5) raise `i_acc` → decrement at E+6, then every 2 edges; `o_time`=0@E+12, response@E+13.
- Zero load: load `i_state`=0, `i_step`=3 at E → `o_time`=0@E, `o_response`=1000@E+1.
- Abort: `i_start` drops at edge E+15 of a 3-tick run → `o_time`=0 and `o_response`=0 at E+15, state IDLE. Reasserting `i_start` with the same values reloads at the next edge.
